// File: rtl/rx_correlation_scheduler.sv
// Purpose : sequences one correlator pass per band-pass sample. It sweeps the
//           organizer chunk addresses, drives the accumulator clear/enable
//           strobes and flags the final result with a timestamp.
// Latency : ord_en starts 1 clk after the trigger; acc strobes lag ord_en by
//           RD_LAT; oresult_valid comes NUM_CHUNKS+RD_LAT+1 clks after the trigger.
// Backpr. : none. A trigger that arrives while busy is dropped and sets the
//           sticky ooverrun flag.
// Ports   : crx_clk/rrx_rst (async, active-low) | erx_en (low = abort/hold)
//           inew_sample_trig, iovr_clr            | ochunk_addr, ord_en -> organizer
//           oacc_clr, oacc_en -> correlator        | oresult_valid, otimestamp -> peak finder
//           obusy, ooverrun -> status
module rx_correlation_scheduler #(
  parameter int NUM_CHUNKS = 100,
  parameter int ADDR_W     = 7,
  parameter int RD_LAT     = 2,
  parameter int TS_W       = 32
) (
  input  logic              crx_clk,
  input  logic              rrx_rst,
  input  logic              erx_en,
  input  logic              inew_sample_trig,
  input  logic              iovr_clr,
  output logic [ADDR_W-1:0] ochunk_addr,
  output logic              ord_en,
  output logic              oacc_clr,
  output logic              oacc_en,
  output logic              oresult_valid,
  output logic [TS_W-1:0]   otimestamp,
  output logic              obusy,
  output logic              ooverrun
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_CHUNKS - 1);
  localparam logic [2:0]        LAST_DRAIN = 3'(RD_LAT - 1);

  state_t            state;
  logic [TS_W-1:0]   sample_cnt;
  logic [2:0]        drain_cnt;
  // Delay lines that align the accumulator strobes with read data arrival.
  logic [RD_LAT-1:0] en_dl;
  logic [RD_LAT-1:0] clr_dl;
  logic              in_sweep;

  assign in_sweep = (state == READ) || (state == DRAIN);
  assign oacc_en  = en_dl[RD_LAT-1];
  assign oacc_clr = clr_dl[RD_LAT-1];

  always_ff @(posedge crx_clk or negedge rrx_rst) begin
    if (!rrx_rst) begin
      state         <= IDLE;
      sample_cnt    <= '0;
      drain_cnt     <= '0;
      en_dl         <= '0;
      clr_dl        <= '0;
      ochunk_addr   <= '0;
      ord_en        <= 1'b0;
      oresult_valid <= 1'b0;
      otimestamp    <= '0;
      obusy         <= 1'b0;
      ooverrun      <= 1'b0;
    end else if (!erx_en) begin
      // Abort: drop the window and flush the pipeline. The counter,
      // timestamp and overrun flag keep their values.
      state         <= IDLE;
      ord_en        <= 1'b0;
      obusy         <= 1'b0;
      oresult_valid <= 1'b0;
      en_dl         <= '0;
      clr_dl        <= '0;
    end else begin
      en_dl[0]  <= ord_en;
      clr_dl[0] <= ord_en && (ochunk_addr == '0);
      for (int i = 1; i < RD_LAT; i++) begin
        en_dl[i]  <= en_dl[i-1];
        clr_dl[i] <= clr_dl[i-1];
      end

      oresult_valid <= 1'b0;

      // Every enabled trigger advances the sample index, even a dropped one.
      if (inew_sample_trig)
        sample_cnt <= sample_cnt + TS_W'(1);

      // Setting the flag takes priority over clearing it.
      if (inew_sample_trig && in_sweep)
        ooverrun <= 1'b1;
      else if (iovr_clr)
        ooverrun <= 1'b0;

      case (state)
        IDLE, DONE: begin
          // DONE accepts a trigger just like IDLE. Its result strobe was
          // issued on entry, so back-to-back windows lose no cycle.
          if (inew_sample_trig) begin
            state       <= READ;
            otimestamp  <= sample_cnt;
            ochunk_addr <= '0;
            ord_en      <= 1'b1;
            obusy       <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        READ: begin
          if (ochunk_addr == LAST_ADDR) begin
            state     <= DRAIN;
            ord_en    <= 1'b0;
            drain_cnt <= '0;
          end else begin
            ochunk_addr <= ochunk_addr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt == LAST_DRAIN) begin
            state         <= DONE;
            obusy         <= 1'b0;
            oresult_valid <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_correlation_scheduler.sv
module tb_rx_correlation_scheduler;

  localparam int NC  = 100;
  localparam int RD  = 2;
  localparam int NC2 = 4;
  localparam int RD2 = 1;

  typedef struct {int ts; int cyc;} exp_t;

  logic        crx_clk = 1'b0;
  logic        rrx_rst = 1'b0;
  logic        erx_en = 1'b1;
  logic        trig = 1'b0;
  logic        ovr_clr = 1'b0;
  logic [6:0]  ochunk_addr;
  logic        ord_en, oacc_clr, oacc_en, oresult_valid, obusy, ooverrun;
  logic [31:0] otimestamp;

  logic        trig2 = 1'b0;
  logic [1:0]  addr2;
  logic        rd2, clr2, en2, rv2, busy2, ovr2;
  logic [3:0]  ts2;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   sc = 0;
  int   sc2 = 0;
  int   res_cyc = -1;
  logic ovr_m = 1'b0;
  exp_t q1[$];
  exp_t q2[$];

  always #5 crx_clk = ~crx_clk;

  rx_correlation_scheduler dut (
    .crx_clk(crx_clk), .rrx_rst(rrx_rst), .erx_en(erx_en),
    .inew_sample_trig(trig), .iovr_clr(ovr_clr),
    .ochunk_addr(ochunk_addr), .ord_en(ord_en), .oacc_clr(oacc_clr),
    .oacc_en(oacc_en), .oresult_valid(oresult_valid), .otimestamp(otimestamp),
    .obusy(obusy), .ooverrun(ooverrun)
  );

  rx_correlation_scheduler #(.NUM_CHUNKS(NC2), .ADDR_W(2), .RD_LAT(RD2), .TS_W(4)) dut2 (
    .crx_clk(crx_clk), .rrx_rst(rrx_rst), .erx_en(1'b1),
    .inew_sample_trig(trig2), .iovr_clr(1'b0),
    .ochunk_addr(addr2), .ord_en(rd2), .oacc_clr(clr2),
    .oacc_en(en2), .oresult_valid(rv2), .otimestamp(ts2),
    .obusy(busy2), .ooverrun(ovr2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Scoreboards: each result strobe must match the oldest accepted window.
  always @(negedge crx_clk) begin
    exp_t e;
    if (rrx_rst && oresult_valid) begin
      if (q1.size() == 0) chk("res_unexpected", 1, 0);
      else begin
        e = q1.pop_front();
        chk("res_ts", otimestamp, e.ts);
        chk("res_cyc", cyc, e.cyc);
      end
    end
    if (rrx_rst && rv2) begin
      if (q2.size() == 0) chk("res2_unexpected", 1, 0);
      else begin
        e = q2.pop_front();
        chk("res2_ts", {28'd0, ts2}, e.ts);
        chk("res2_cyc", cyc, e.cyc);
      end
    end
  end

  task automatic step();
    @(posedge crx_clk);
    #1;
    cyc++;
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic do_reset();
    @(negedge crx_clk);
    rrx_rst = 1'b0; trig = 1'b0; trig2 = 1'b0; erx_en = 1'b1; ovr_clr = 1'b0;
    repeat (3) @(negedge crx_clk);
    chk("rst_ord_en", ord_en, 0);
    chk("rst_busy", obusy, 0);
    chk("rst_ts", otimestamp, 0);
    chk("rst_ovr", ooverrun, 0);
    chk("rst_acc_en", oacc_en, 0);
    chk("rst_rv", oresult_valid, 0);
    rrx_rst = 1'b1;
    @(posedge crx_clk);
    #1;
    cyc = 0; sc = 0; sc2 = 0; res_cyc = -1; ovr_m = 1'b0;
  endtask

  // Drives one trigger in cycle n and records the bench's expectation.
  task automatic trig_at(input int n);
    wait_to(n);
    trig = 1'b1;
    if (res_cyc < 0 || cyc >= res_cyc) begin
      res_cyc = cyc + NC + RD + 1;
      q1.push_back('{sc, res_cyc});
    end else begin
      ovr_m = 1'b1;
    end
    sc++;
    step();
    trig = 1'b0;
  endtask

  initial begin
    // 1: single window, cycle-exact strobe check
    do_reset();
    trig_at(10);
    while (cyc <= 120) begin
      chk("t1_rd_en", ord_en, (cyc >= 11 && cyc <= 110));
      if (cyc >= 11 && cyc <= 110) chk("t1_addr", ochunk_addr, cyc - 11);
      if (cyc >= 111 && cyc <= 112) chk("t1_addr_hold", ochunk_addr, 99);
      chk("t1_acc_clr", oacc_clr, (cyc == 13));
      chk("t1_acc_en", oacc_en, (cyc >= 13 && cyc <= 112));
      chk("t1_busy", obusy, (cyc >= 11 && cyc <= 112));
      chk("t1_rv", oresult_valid, (cyc == 113));
      chk("t1_ts", otimestamp, 0);
      step();
    end

    // 2: five evenly spaced windows
    do_reset();
    for (int i = 0; i < 5; i++) trig_at(10 + 128 * i);
    wait_to(10 + 128 * 4 + 110);
    chk("t2_ovr", ooverrun, ovr_m);

    // 3: overrun during a window, then sticky until cleared
    do_reset();
    trig_at(10);
    trig_at(60);
    chk("t3_ovr_set", ooverrun, ovr_m);
    chk("t3_ts_hold", otimestamp, 0);
    trig_at(200);
    wait_to(399);
    chk("t3_ovr_sticky", ooverrun, 1);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    ovr_m = 1'b0;
    chk("t3_ovr_clr", ooverrun, ovr_m);

    // 4: trigger coincident with DONE starts the next window immediately
    do_reset();
    trig_at(10);
    trig_at(113);
    chk("t4_rd_en_first", ord_en, 1);
    chk("t4_addr_first", ochunk_addr, 0);
    chk("t4_ts", otimestamp, 1);
    chk("t4_busy", obusy, 1);
    wait_to(213);
    chk("t4_rd_en_last", ord_en, 1);
    chk("t4_addr_last", ochunk_addr, 99);
    step();
    chk("t4_rd_en_off", ord_en, 0);
    chk("t4_ovr", ooverrun, 0);
    wait_to(220);

    // 5: disable mid-window aborts without a result; triggers not counted
    do_reset();
    trig_at(10);
    wait_to(50);
    erx_en = 1'b0;
    step();
    void'(q1.pop_back());
    res_cyc = -1;
    repeat (4) begin
      chk("t5_rd_en", ord_en, 0);
      chk("t5_acc_en", oacc_en, 0);
      chk("t5_acc_clr", oacc_clr, 0);
      chk("t5_busy", obusy, 0);
      chk("t5_rv", oresult_valid, 0);
      chk("t5_ts_hold", otimestamp, 0);
      trig = (cyc == 52);
      step();
    end
    trig = 1'b0;
    erx_en = 1'b1;
    chk("t5_ovr", ooverrun, 0);
    trig_at(70);
    chk("t5_ts_new", otimestamp, 1);
    wait_to(180);

    // 6: async reset mid-READ
    do_reset();
    trig_at(10);
    wait_to(40);
    rrx_rst = 1'b0;
    #2;
    chk("t6_rd_en", ord_en, 0);
    chk("t6_busy", obusy, 0);
    chk("t6_addr", ochunk_addr, 0);
    chk("t6_acc_en", oacc_en, 0);
    void'(q1.pop_back());
    do_reset();
    trig_at(10);
    wait_to(120);

    // 6b: 4-bit timestamp wraps on the 17th trigger (small instance)
    do_reset();
    for (int i = 0; i < 17; i++) begin
      wait_to(10 + 8 * i);
      trig2 = 1'b1;
      q2.push_back('{sc2 % 16, cyc + NC2 + RD2 + 1});
      sc2++;
      if (i == 16) begin
        step();
        trig2 = 1'b0;
        chk("t6b_rd_en", rd2, 1);
        step();
        chk("t6b_acc_clr", clr2, 1);
      end else begin
        step();
        trig2 = 1'b0;
      end
    end
    wait_to(10 + 8 * 16 + 12);
    chk("t6b_busy_end", busy2, 0);

    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
